// File: rtl/input_event_router_pkg.sv
// Shared definitions for the push-button input event router: consumer channel IDs,
// per-button FSM encoding and counter width helper.
package input_event_router_pkg;

  typedef enum logic [1:0] {
    CH_PROCESS = 2'd0,
    CH_ACCESS  = 2'd1,
    CH_GAME    = 2'd2,
    CH_SCORE   = 2'd3
  } chan_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_event_router_button_event_gen.sv
// One push-button: 2-FF synchroniser, debounce counter and press/auto-repeat FSM.
// state     | meaning
// ST_IDLE   | released; a debounced press emits the press pulse
// ST_PRESS  | held, timing the initial repeat delay
// ST_REPEAT | held, emitting a pulse every repeat period while enabled
module input_event_router_button_event_gen
  import input_event_router_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  output logic held_o,
  output logic pulse_o
);

  localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int TMR_W   = cnt_width(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_TC     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] DELAY_LD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LD = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic             POL       = (ACTIVE_LOW != 0);

  logic              sync1_q, sync2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              held_q, held_d;
  btn_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              pulse;

  // Polarity is folded in before the first flop so reset (0) means "released".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i ^ POL;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_cnt_d = db_cnt_q;
    held_d   = held_q;
    if (sync2_q == held_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_TC) begin
      held_d   = ~held_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
      held_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse   = 1'b0;
    if (!held_q) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRESS;
          tmr_d   = DELAY_LD;
          pulse   = 1'b1;
        end
        ST_PRESS: begin
          if (tmr_q == '0) begin
            // Without repeat the timer parks at zero; enabling later starts repeating.
            if (repeat_en_i) begin
              pulse   = 1'b1;
              state_d = ST_REPEAT;
              tmr_d   = PERIOD_LD;
            end
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        ST_REPEAT: begin
          if (tmr_q == '0) begin
            pulse = repeat_en_i;
            tmr_d = PERIOD_LD;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  assign held_o  = held_q;
  assign pulse_o = pulse;

endmodule

// File: rtl/input_event_router.sv
// Push-button front end: one event generator per button, routed to the consumer chosen by sel.
// Buttons still held across a channel switch are blocked until released.
module input_event_router
  import input_event_router_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int NUM_CHANNELS    = int'(CH_SCORE) + 1,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int SEL_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BUTTONS-1:0]            btn_raw,
  input  logic [SEL_W-1:0]                  sel,
  input  logic [NUM_BUTTONS-1:0]            repeat_en,
  output logic [NUM_CHANNELS*NUM_BUTTONS-1:0] evt_out,
  output logic [NUM_BUTTONS-1:0]            held
);

  localparam int NB = NUM_BUTTONS;
  localparam int NC = NUM_CHANNELS;

  logic [NB-1:0]    pulse;
  logic [NB-1:0]    held_w;
  logic [SEL_W-1:0] sel_q;
  logic [NB-1:0]    blocked_q, blocked_d;
  logic [NC*NB-1:0] evt_q, evt_d;

  for (genvar b = 0; b < NB; b++) begin : g_btn
    input_event_router_button_event_gen #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_btn (
      .clk_i      (clk),
      .rst_i      (rst),
      .btn_raw_i  (btn_raw[b]),
      .repeat_en_i(repeat_en[b]),
      .held_o     (held_w[b]),
      .pulse_o    (pulse[b])
    );
  end

  // Set together with the sel_q update so the new consumer never sees a held key.
  always_comb begin
    blocked_d = held_w & (blocked_q | {NB{sel != sel_q}});
  end

  always_comb begin
    evt_d = '0;
    for (int ch = 0; ch < NC; ch++) begin
      for (int b = 0; b < NB; b++) begin
        evt_d[ch*NB + b] = pulse[b] & ~blocked_q[b] & (sel_q == SEL_W'(ch));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      blocked_q <= '0;
      evt_q     <= '0;
    end else begin
      sel_q     <= sel;
      blocked_q <= blocked_d;
      evt_q     <= evt_d;
    end
  end

  assign evt_out = evt_q;
  assign held    = held_w;

endmodule

// File: tb/tb_input_event_router.sv
// Directed bench for input_event_router: expected event pulses are queued with their due cycle
// and compared against evt_out on every falling edge.
module tb_input_event_router;
  import input_event_router_pkg::*;

  localparam int NB = 3;
  localparam int NC = 4;
  localparam int SW = 3;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  // Edges from driving the raw level to the registered event becoming visible.
  localparam int EVT_LAT  = 1 + D + 3;
  localparam int HELD_LAT = 1 + D + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NB-1:0]    btn_raw;
  logic [SW-1:0]    sel;
  logic [NB-1:0]    repeat_en;
  logic [NC*NB-1:0] evt_out;
  logic [NB-1:0]    held;

  always #5 clk = ~clk;

  input_event_router #(
    .NUM_BUTTONS    (NB),
    .NUM_CHANNELS   (NC),
    .ACTIVE_LOW     (1),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .SEL_W          (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .sel      (sel),
    .repeat_en(repeat_en),
    .evt_out  (evt_out),
    .held     (held)
  );

  typedef struct {
    int cyc;
    int idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic expect_evt(input int at, input int idx);
    exp_t e;
    e.cyc = at;
    e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic check_evt();
    logic [NC*NB-1:0] exp_v;
    exp_v = '0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        if (sb_q[i].cyc == cyc) exp_v[sb_q[i].idx] = 1'b1;
        sb_q.delete(i);
      end
    end
    checks++;
    assert (evt_out === exp_v) else begin
      errors++;
      $error("FAIL evt cyc=%0d observed=%h expected=%h", cyc, evt_out, exp_v);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_evt();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int c0, c1, rel;
    int ch_game, ch_proc;
    ch_game = int'(CH_GAME);
    ch_proc = int'(CH_PROCESS);

    rst       = 1'b1;
    btn_raw   = '1;
    repeat_en = '0;
    sel       = 3'd2;
    ticks(2);
    chk("reset_held", 32'(held), 32'd0);
    chk("reset_evt", 32'(evt_out), 32'd0);
    rst = 1'b0;
    ticks(5);

    // 1: single press, no repeat
    c0 = cyc;
    btn_raw[0] = 1'b0;
    expect_evt(c0 + EVT_LAT, ch_game*NB + 0);
    ticks(HELD_LAT - 1);
    chk("s1_held_before", 32'(held[0]), 32'd0);
    tick();
    chk("s1_held_rise", 32'(held[0]), 32'd1);
    ticks(40 - HELD_LAT);
    btn_raw[0] = 1'b1;
    ticks(HELD_LAT - 1);
    chk("s1_held_before_fall", 32'(held[0]), 32'd1);
    tick();
    chk("s1_held_fall", 32'(held[0]), 32'd0);
    ticks(10);

    // 2: press with auto-repeat
    repeat_en = 3'b001;
    c0 = cyc;
    btn_raw[0] = 1'b0;
    expect_evt(c0 + EVT_LAT, ch_game*NB + 0);
    rel = c0 + 30;
    for (int t = c0 + EVT_LAT + RD; t <= rel + HELD_LAT; t += RP)
      expect_evt(t, ch_game*NB + 0);
    ticks(30);
    btn_raw[0] = 1'b1;
    ticks(20);
    chk("s2_released", 32'(held[0]), 32'd0);
    repeat_en = '0;

    // 3: bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = 1'b0;
      ticks(3);
      btn_raw[1] = 1'b1;
      tick();
      chk("s3_bounce_held", 32'(held[1]), 32'd0);
    end
    ticks(10);
    chk("s3_final_held", 32'(held[1]), 32'd0);

    // 4: channel switch while btn0 held, btn0 repeats must not leak
    repeat_en = 3'b001;
    c0 = cyc;
    btn_raw[0] = 1'b0;
    expect_evt(c0 + EVT_LAT, ch_game*NB + 0);
    ticks(10);
    sel = 3'(ch_proc);
    ticks(4);
    c1 = cyc;
    btn_raw[1] = 1'b0;
    expect_evt(c1 + EVT_LAT, ch_proc*NB + 1);
    ticks(12);
    chk("s4_both_held", 32'(held), 32'b011);
    btn_raw[0] = 1'b1;
    btn_raw[1] = 1'b1;
    repeat_en  = '0;
    ticks(12);
    chk("s4_released", 32'(held), 32'd0);
    c0 = cyc;
    btn_raw[0] = 1'b0;
    expect_evt(c0 + EVT_LAT, ch_proc*NB + 0);
    ticks(10);
    btn_raw[0] = 1'b1;
    ticks(10);

    // 5: out-of-range channel select
    sel       = 3'd5;
    repeat_en = 3'b100;
    ticks(3);
    btn_raw[2] = 1'b0;
    ticks(HELD_LAT);
    chk("s5_held2", 32'(held[2]), 32'd1);
    ticks(10);
    btn_raw[2] = 1'b1;
    repeat_en  = '0;
    ticks(10);
    chk("s5_released", 32'(held), 32'd0);

    // 6: reset pulse while repeating
    sel       = 3'd2;
    repeat_en = 3'b001;
    ticks(3);
    c0 = cyc;
    btn_raw[0] = 1'b0;
    expect_evt(c0 + EVT_LAT, ch_game*NB + 0);
    expect_evt(c0 + EVT_LAT + RD, ch_game*NB + 0);
    expect_evt(c0 + EVT_LAT + RD + RP, ch_game*NB + 0);
    ticks(EVT_LAT + RD + RP);
    rst = 1'b1;
    #1;
    chk("s6_rst_evt", 32'(evt_out), 32'd0);
    chk("s6_rst_held", 32'(held), 32'd0);
    tick();
    rst = 1'b0;
    c1 = cyc;
    // First sampling edge is the one right after reset falls.
    expect_evt(c1 + EVT_LAT, ch_game*NB + 0);
    rel = c1 + EVT_LAT + RD + 2*RP + 1;
    for (int t = c1 + EVT_LAT + RD; t <= rel + HELD_LAT; t += RP)
      expect_evt(t, ch_game*NB + 0);
    ticks(rel - c1);
    btn_raw[0] = 1'b1;
    ticks(20);
    chk("s6_released", 32'(held), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
